// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the RV32IM 5-stage core.
// Resolves RAW forwarding into E, load-use stalls, taken-branch/jump flushes,
// and holds a multi-cycle DIV/REM in E while bubbles are fed into M.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   Rs1D, Rs2D               D-stage source registers
//   Rs1E, Rs2E, RdE          E-stage sources / destination
//   ResultSrcE               E-stage result select (2'b01 = load)
//   PCSrcE                   E-stage branch taken or jump
//   DivE                     E-stage instruction is a divide/remainder
//   RdM, RegWriteM           M-stage destination / write enable
//   RdW, RegWriteW           W-stage destination / write enable
//   StallF, StallD, StallE   hold fetch PC / D register / E register
//   FlushD, FlushE, FlushM   synchronous clear of D / E / M registers
//   ForwardAE, ForwardBE     00 regfile, 01 W result, 10 M ALU result
//   DivStartE                one-cycle divider start pulse
//   DivDoneE                 divider result valid this cycle
module hazard_ctrl #(
  parameter int unsigned DIV_LATENCY = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [1:0] ResultSrcE,
  input  logic       PCSrcE,
  input  logic       DivE,
  input  logic [4:0] RdM,
  input  logic       RegWriteM,
  input  logic [4:0] RdW,
  input  logic       RegWriteW,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       DivStartE,
  output logic       DivDoneE
);

  localparam int unsigned CW = $clog2(DIV_LATENCY + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(DIV_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          lw_stall;
  logic          div_stall;

  // DONE lasts one cycle so the divide still sitting in E (DivE high)
  // is not mistaken for a new one and restarted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (DivE) begin
            cnt   <= CNT_INIT;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state <= DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // M has priority over W: it holds the younger result.
  always_comb begin
    ForwardAE = 2'b00;
    if (RegWriteM && (RdM != '0) && (RdM == Rs1E)) begin
      ForwardAE = 2'b10;
    end else if (RegWriteW && (RdW != '0) && (RdW == Rs1E)) begin
      ForwardAE = 2'b01;
    end
  end

  always_comb begin
    ForwardBE = 2'b00;
    if (RegWriteM && (RdM != '0) && (RdM == Rs2E)) begin
      ForwardBE = 2'b10;
    end else if (RegWriteW && (RdW != '0) && (RdW == Rs2E)) begin
      ForwardBE = 2'b01;
    end
  end

  always_comb begin
    lw_stall  = (ResultSrcE == 2'b01) && (RdE != '0) &&
                ((RdE == Rs1D) || (RdE == Rs2D));
    div_stall = ((state == IDLE) && DivE) || (state == BUSY);

    StallF    = lw_stall | div_stall;
    StallD    = lw_stall | div_stall;
    StallE    = div_stall;
    FlushD    = PCSrcE;
    FlushE    = lw_stall | PCSrcE;
    FlushM    = div_stall;
    DivStartE = (state == IDLE) && DivE;
    DivDoneE  = (state == DONE);
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: self-checking bench for hazard_ctrl.
// Two instances share the inputs: DIV_LATENCY=4 (main) and DIV_LATENCY=1
// (shortest divide). Outputs are packed as
// {StallF,StallD,StallE,FlushD,FlushE,FlushM,ForwardAE,ForwardBE,DivStartE,DivDoneE}.
module tb_hazard_ctrl;

  localparam int L4 = 4;
  localparam int L1 = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] ResultSrcE;
  logic       PCSrcE, DivE, RegWriteM, RegWriteW;

  logic       a_sf, a_sd, a_se, a_fd, a_fe, a_fm, a_ds, a_dd;
  logic [1:0] a_fa, a_fb;
  logic       b_sf, b_sd, b_se, b_fd, b_fe, b_fm, b_ds, b_dd;
  logic [1:0] b_fa, b_fb;
  logic [11:0] out4, out1;

  assign out4 = {a_sf, a_sd, a_se, a_fd, a_fe, a_fm, a_fa, a_fb, a_ds, a_dd};
  assign out1 = {b_sf, b_sd, b_se, b_fd, b_fe, b_fm, b_fa, b_fb, b_ds, b_dd};

  always #5 clk = ~clk;

  hazard_ctrl #(.DIV_LATENCY(L4)) dut (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .DivE(DivE),
    .RdM(RdM), .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW),
    .StallF(a_sf), .StallD(a_sd), .StallE(a_se), .FlushD(a_fd), .FlushE(a_fe),
    .FlushM(a_fm), .ForwardAE(a_fa), .ForwardBE(a_fb), .DivStartE(a_ds),
    .DivDoneE(a_dd)
  );

  hazard_ctrl #(.DIV_LATENCY(L1)) dut1 (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .DivE(DivE),
    .RdM(RdM), .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW),
    .StallF(b_sf), .StallD(b_sd), .StallE(b_se), .FlushD(b_fd), .FlushE(b_fe),
    .FlushM(b_fm), .ForwardAE(b_fa), .ForwardBE(b_fb), .DivStartE(b_ds),
    .DivDoneE(b_dd)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %b want %b", name, act, exp);
  endtask

  typedef struct {
    string      name;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic [1:0] rsrc;
    logic       pcsrc, rwm, rww;
    logic [11:0] exp;
  } vec_t;

  function automatic vec_t mk(input string n, input logic [4:0] rs1d, input logic [4:0] rs2d,
                              input logic [4:0] rs1e, input logic [4:0] rs2e,
                              input logic [4:0] rde, input logic [1:0] rsrc, input logic pcsrc,
                              input logic [4:0] rdm, input logic rwm,
                              input logic [4:0] rdw, input logic rww, input logic [11:0] exp);
    vec_t v;
    v.name = n; v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e;
    v.rde = rde; v.rsrc = rsrc; v.pcsrc = pcsrc; v.rdm = rdm; v.rwm = rwm;
    v.rdw = rdw; v.rww = rww; v.exp = exp;
    return v;
  endfunction

  task automatic clear_inputs();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    ResultSrcE = '0; PCSrcE = 1'b0; DivE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    #1;
    check("reset_zero", out4, 12'b0);
    check("reset_zero_l1", out1, 12'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Reference model: the divider is tracked as "cycles since start"
  // (-1 = no divide in progress); BUSY covers ages 1..L, result at age L+1.
  function automatic logic [11:0] model(input int age, input int lat);
    logic [1:0] fa, fb;
    logic lw, dstall, start, done;
    fa = 2'b00;
    if (RegWriteM && RdM != 0 && RdM == Rs1E) fa = 2'b10;
    else if (RegWriteW && RdW != 0 && RdW == Rs1E) fa = 2'b01;
    fb = 2'b00;
    if (RegWriteM && RdM != 0 && RdM == Rs2E) fb = 2'b10;
    else if (RegWriteW && RdW != 0 && RdW == Rs2E) fb = 2'b01;
    lw = (ResultSrcE == 2'b01) && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    start  = (age < 0) && DivE;
    dstall = start || (age >= 1 && age <= lat);
    done   = (age == lat + 1);
    return {lw | dstall, lw | dstall, dstall, PCSrcE, lw | PCSrcE, dstall, fa, fb, start, done};
  endfunction

  function automatic int next_age(input int age, input int lat);
    if (age < 0) return DivE ? 1 : -1;
    if (age == lat + 1) return -1;
    return age + 1;
  endfunction

  vec_t tbl[$];

  initial begin
    clear_inputs();
    rst = 1'b1;

    //                 name         rs1d rs2d rs1e rs2e rde rsrc pc  rdm rwm rdw rww  exp
    tbl.push_back(mk("fwd_m_pri",     0,  0,   5,   0,  0, 2'b00, 0, 5, 1, 5, 1, 12'b000000_10_00_00));
    tbl.push_back(mk("fwd_w",         0,  0,   5,   0,  0, 2'b00, 0, 5, 0, 5, 1, 12'b000000_01_00_00));
    tbl.push_back(mk("fwd_x0",        0,  0,   0,   0,  0, 2'b00, 0, 0, 1, 0, 1, 12'b000000_00_00_00));
    tbl.push_back(mk("fwd_b_m_a_w",   0,  0,   3,   9,  0, 2'b00, 0, 9, 1, 3, 1, 12'b000000_01_10_00));
    tbl.push_back(mk("fwd_nowrite",   0,  0,   4,   4,  0, 2'b00, 0, 4, 0, 4, 0, 12'b000000_00_00_00));
    tbl.push_back(mk("lw_rs2",        0,  7,   0,   0,  7, 2'b01, 0, 0, 0, 0, 0, 12'b110010_00_00_00));
    tbl.push_back(mk("lw_rd0",        0,  0,   0,   0,  0, 2'b01, 0, 0, 0, 0, 0, 12'b000000_00_00_00));
    tbl.push_back(mk("lw_rs1",        7,  3,   0,   0,  7, 2'b01, 0, 0, 0, 0, 0, 12'b110010_00_00_00));
    tbl.push_back(mk("nonload",       7,  7,   0,   0,  7, 2'b00, 0, 0, 0, 0, 0, 12'b000000_00_00_00));
    tbl.push_back(mk("src10",         7,  7,   0,   0,  7, 2'b10, 0, 0, 0, 0, 0, 12'b000000_00_00_00));
    tbl.push_back(mk("branch",        0,  0,   0,   0,  0, 2'b00, 1, 0, 0, 0, 0, 12'b000110_00_00_00));
    tbl.push_back(mk("branch_lw",     0,  7,   0,   0,  7, 2'b01, 1, 0, 0, 0, 0, 12'b110110_00_00_00));

    do_reset();

    // Combinational vectors with no divide in flight.
    foreach (tbl[i]) begin
      Rs1D = tbl[i].rs1d; Rs2D = tbl[i].rs2d; Rs1E = tbl[i].rs1e; Rs2E = tbl[i].rs2e;
      RdE = tbl[i].rde; ResultSrcE = tbl[i].rsrc; PCSrcE = tbl[i].pcsrc;
      RdM = tbl[i].rdm; RegWriteM = tbl[i].rwm; RdW = tbl[i].rdw; RegWriteW = tbl[i].rww;
      DivE = 1'b0;
      #1;
      check(tbl[i].name, out4, tbl[i].exp);
    end

    // Load-use across a clock: load moves to M, stall drops.
    do_reset();
    ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
    #1;
    check("lu_cycle0", out4, 12'b110010_00_00_00);
    @(posedge clk); #1;
    ResultSrcE = 2'b00; RdE = 5'd0; RdM = 5'd7; RegWriteM = 1'b1; Rs2E = 5'd7;
    #1;
    check("lu_cycle1", out4, 12'b000000_00_10_00);

    // Two back-to-back divides, DIV_LATENCY=4, DivE held high.
    do_reset();
    DivE = 1'b1;
    for (int c = 0; c < 2 * (L4 + 2); c++) begin
      logic s;
      int ph;
      ph = c % (L4 + 2);
      s  = (ph <= L4);
      #1;
      check($sformatf("div4_c%0d", c), out4,
            {s, s, s, 1'b0, 1'b0, s, 4'b0000, ph == 0, ph == L4 + 1});
      @(posedge clk); #1;
    end
    DivE = 1'b0;
    #1;
    check("div4_idle", out4, 12'b0);

    // Reset in BUSY with cnt=2 aborts at once; DivE drops with reset.
    do_reset();
    DivE = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rstmid_busy", out4, 12'b111001_00_00_00);
    rst = 1'b1; DivE = 1'b0;
    #1;
    check("rstmid_abort", out4, 12'b0);
    @(posedge clk); #1;
    rst = 1'b0; DivE = 1'b1;
    #1;
    check("rstmid_restart", out4, 12'b111001_00_00_10);

    // Shortest divide, DIV_LATENCY=1.
    do_reset();
    DivE = 1'b1;
    for (int c = 0; c < 4; c++) begin
      logic s;
      int ph;
      ph = c % (L1 + 2);
      s  = (ph <= L1);
      #1;
      check($sformatf("div1_c%0d", c), out1,
            {s, s, s, 1'b0, 1'b0, s, 4'b0000, ph == 0, ph == L1 + 1});
      @(posedge clk); #1;
    end

    // Randomized run against the reference model.
    do_reset();
    begin
      int age4, age1;
      age4 = -1;
      age1 = -1;
      for (int n = 0; n < 600; n++) begin
        Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
        Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
        RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
        RdW  = 5'($urandom_range(0, 3));
        ResultSrcE = 2'($urandom_range(0, 3));
        PCSrcE    = ($urandom_range(0, 5) == 0);
        DivE      = ($urandom_range(0, 3) == 0);
        RegWriteM = 1'($urandom_range(0, 1));
        RegWriteW = 1'($urandom_range(0, 1));
        #2;
        check($sformatf("rand4_%0d", n), out4, model(age4, L4));
        check($sformatf("rand1_%0d", n), out1, model(age1, L1));
        age4 = next_age(age4, L4);
        age1 = next_age(age1, L1);
        @(posedge clk); #1;
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
